pe_scatter_accum: RTL and testbench

//  Next-generation PE output adder: scatters NUM_PE signed partial products per beat into an
//  OUT_ROWS x OUT_COLS accumulator map at their (row,col), summing same-cell collisions, over a

---
 rtl/pe_scatter_accum.sv | 173 +++++++++++++++++
 tb/tb_pe_scatter_accum.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_scatter_accum.sv
// Scatter-accumulator between the PE array and the output feature buffer: per-lane products are summed
// into a row/col cell map over a frame, then the map is streamed out as saturated words.
module pe_scatter_accum #(
  parameter int NUM_PE   = 16,
  parameter int DATA_W   = 16,
  parameter int COORD_W  = 8,
  parameter int ACC_W    = 24,
  parameter int OUT_ROWS = 5,
  parameter int OUT_COLS = 5,
  localparam int N       = OUT_ROWS * OUT_COLS,
  localparam int IDX_W   = $clog2(N)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_PE*DATA_W-1:0]    data_in,
  input  logic [NUM_PE*COORD_W-1:0]   data_in_cols,
  input  logic [NUM_PE*COORD_W-1:0]   data_in_rows,
  input  logic                        frame_end,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic [IDX_W-1:0]            out_index,
  output logic                        out_last,
  output logic                        busy,
  output logic [15:0]                 drop_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam logic signed [COORD_W-1:0] ROW_LIM = COORD_W'(OUT_ROWS);
  localparam logic signed [COORD_W-1:0] COL_LIM = COORD_W'(OUT_COLS);
  localparam logic signed [ACC_W-1:0]   SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]   SAT_MIN = ~SAT_MAX;
  localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(N - 1);

  state_t                    r_state;
  state_t                    w_nextState;
  logic signed [ACC_W-1:0]   r_cells [N];
  logic signed [ACC_W-1:0]   w_cellNext [N];
  logic signed [ACC_W-1:0]   w_laneData [NUM_PE];
  logic signed [COORD_W-1:0] w_laneRow [NUM_PE];
  logic signed [COORD_W-1:0] w_laneCol [NUM_PE];
  logic [NUM_PE-1:0]         w_laneInBounds;
  logic [CNT_W-1:0]          w_dropBeat;
  logic [16:0]               w_dropSum;
  logic [15:0]               r_dropCount;
  logic [IDX_W-1:0]          r_outIndex;
  logic signed [ACC_W-1:0]   w_drainCell;
  logic                      w_accept;
  logic                      w_clear;

  // A beat arriving together with frame_start is discarded; frame_start is ignored while draining.
  assign w_accept = (r_state == ACCUM) && in_valid && !frame_start;
  assign w_clear  = frame_start && (r_state != DRAIN);

  always_comb begin
    w_dropBeat = '0;
    for (int k = 0; k < NUM_PE; k++) begin
      w_laneData[k]     = ACC_W'($signed(data_in[k*DATA_W +: DATA_W]));
      w_laneRow[k]      = data_in_rows[k*COORD_W +: COORD_W];
      w_laneCol[k]      = data_in_cols[k*COORD_W +: COORD_W];
      w_laneInBounds[k] = !w_laneRow[k][COORD_W-1] && (w_laneRow[k] < ROW_LIM) &&
                          !w_laneCol[k][COORD_W-1] && (w_laneCol[k] < COL_LIM);
      if (!w_laneInBounds[k]) begin
        w_dropBeat = w_dropBeat + CNT_W'(1);
      end
    end
    w_dropSum = {1'b0, r_dropCount} + 17'(w_dropBeat);
  end

  // Every lane landing on a cell is folded into one sum so same-beat collisions never lose updates.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      w_cellNext[c] = r_cells[c];
      for (int k = 0; k < NUM_PE; k++) begin
        if (w_laneInBounds[k] &&
            (w_laneRow[k] == COORD_W'(c / OUT_COLS)) &&
            (w_laneCol[k] == COORD_W'(c % OUT_COLS))) begin
          w_cellNext[c] = w_cellNext[c] + w_laneData[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) begin
          w_nextState = ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (w_accept && frame_end) begin
          w_nextState = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready && (r_outIndex == LAST_IDX)) begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      for (int c = 0; c < N; c++) begin
        r_cells[c] <= '0;
      end
    end else if (w_accept) begin
      for (int c = 0; c < N; c++) begin
        r_cells[c] <= w_cellNext[c];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_dropCount <= '0;
    end else if (w_accept) begin
      r_dropCount <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end
  end

  // The drain pointer wraps back to zero on the final handshake, ready for the next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outIndex <= '0;
    end else if ((r_state == DRAIN) && out_ready) begin
      r_outIndex <= (r_outIndex == LAST_IDX) ? '0 : r_outIndex + IDX_W'(1);
    end else if (w_clear) begin
      r_outIndex <= '0;
    end
  end

  always_comb begin
    w_drainCell = r_cells[r_outIndex];
    if (w_drainCell > SAT_MAX) begin
      out_data = SAT_MAX[DATA_W-1:0];
    end else if (w_drainCell < SAT_MIN) begin
      out_data = SAT_MIN[DATA_W-1:0];
    end else begin
      out_data = w_drainCell[DATA_W-1:0];
    end
  end

  assign out_index  = r_outIndex;
  assign out_last   = (r_state == DRAIN) && (r_outIndex == LAST_IDX);
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_pe_scatter_accum.sv
// Bench for pe_scatter_accum: a frame-level cell-map model checked every cycle on the falling edge,
// plus hand-computed cell and drop-count values pinned at the end of each completed drain.
module tb_pe_scatter_accum;

  localparam int NUM_PE  = 16;
  localparam int DATA_W  = 16;
  localparam int COORD_W = 8;
  localparam int N       = 25;
  localparam int IDX_W   = 5;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      frame_start = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      frame_end = 1'b0;
  logic                      out_ready = 1'b0;
  logic [NUM_PE*DATA_W-1:0]  data_in = '0;
  logic [NUM_PE*COORD_W-1:0] data_in_cols = '0;
  logic [NUM_PE*COORD_W-1:0] data_in_rows = '0;
  logic                      in_ready;
  logic                      out_valid;
  logic                      out_last;
  logic                      busy;
  logic [DATA_W-1:0]         out_data;
  logic [IDX_W-1:0]          out_index;
  logic [15:0]               drop_count;

  pe_scatter_accum dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_in      (data_in),
    .data_in_cols (data_in_cols),
    .data_in_rows (data_in_rows),
    .frame_end    (frame_end),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef enum {P_IDLE, P_ACC, P_DRAIN} phase_t;

  int     errors = 0;
  int     checks = 0;
  phase_t mPhase = P_IDLE;
  longint mCell [N];
  int     mDrop = 0;
  int     mIdx = 0;
  int     framesDone = 0;
  bit     justReset = 1'b1;
  int     capData [N];

  bit     litMask [N];
  int     litVal [N];
  int     litDrop = 0;
  int     laneData [NUM_PE];
  int     laneRow [NUM_PE];
  int     laneCol [NUM_PE];

  function automatic longint wrapAcc(input longint v);
    logic [23:0] t;
    t = v[23:0];
    return longint'($signed(t));
  endfunction

  function automatic longint satWord(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Check the outputs against the model, then advance the model by what the next rising edge will see.
  always @(negedge clk) begin
    checkOutput("busy", longint'(busy), longint'(mPhase != P_IDLE));
    checkOutput("in_ready", longint'(in_ready), longint'(mPhase == P_ACC));
    checkOutput("out_valid", longint'(out_valid), longint'(mPhase == P_DRAIN));
    checkOutput("drop_count", longint'(drop_count), longint'(mDrop));
    if (justReset) begin
      checkOutput("reset out_index", longint'(out_index), 0);
      checkOutput("reset out_last", longint'(out_last), 0);
    end
    if (mPhase == P_DRAIN) begin
      checkOutput("out_index", longint'(out_index), longint'(mIdx));
      checkOutput("out_data", longint'($signed(out_data)), satWord(mCell[mIdx]));
      checkOutput("out_last", longint'(out_last), longint'(mIdx == N - 1));
    end

    if (rst) begin
      for (int c = 0; c < N; c++) mCell[c] = 0;
      mDrop = 0;
      mIdx = 0;
      mPhase = P_IDLE;
      justReset = 1'b1;
    end else begin
      justReset = 1'b0;
      case (mPhase)
        P_IDLE: begin
          if (frame_start) begin
            for (int c = 0; c < N; c++) mCell[c] = 0;
            mDrop = 0;
            mPhase = P_ACC;
          end
        end
        P_ACC: begin
          if (frame_start) begin
            for (int c = 0; c < N; c++) mCell[c] = 0;
            mDrop = 0;
          end else if (in_valid) begin
            for (int k = 0; k < NUM_PE; k++) begin
              int r;
              int cc;
              r  = int'($signed(data_in_rows[k*COORD_W +: COORD_W]));
              cc = int'($signed(data_in_cols[k*COORD_W +: COORD_W]));
              if (r >= 0 && r < 5 && cc >= 0 && cc < 5) begin
                mCell[r*5+cc] = wrapAcc(mCell[r*5+cc] + longint'($signed(data_in[k*DATA_W +: DATA_W])));
              end else if (mDrop < 65535) begin
                mDrop = mDrop + 1;
              end
            end
            if (frame_end) begin
              mPhase = P_DRAIN;
              mIdx = 0;
            end
          end
        end
        P_DRAIN: begin
          if (out_ready) begin
            capData[mIdx] = int'($signed(out_data));
            if (mIdx == N - 1) begin
              for (int i = 0; i < N; i++) begin
                if (litMask[i]) checkOutput($sformatf("lit cell %0d", i), capData[i], litVal[i]);
              end
              checkOutput("lit drop_count", longint'(drop_count), longint'(litDrop));
              mIdx = 0;
              mPhase = P_IDLE;
              framesDone++;
            end else begin
              mIdx++;
            end
          end
        end
        default: mPhase = P_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearLanes();
    for (int k = 0; k < NUM_PE; k++) begin
      laneData[k] = 0;
      laneRow[k] = -1;
      laneCol[k] = -1;
    end
  endtask

  task automatic setAllLanes(input int d, input int r, input int c);
    for (int k = 0; k < NUM_PE; k++) begin
      laneData[k] = d;
      laneRow[k] = r;
      laneCol[k] = c;
    end
  endtask

  task automatic clearLits(input int drop);
    for (int i = 0; i < N; i++) litMask[i] = 1'b0;
    litDrop = drop;
  endtask

  task automatic setLit(input int idx, input int val);
    litMask[idx] = 1'b1;
    litVal[idx] = val;
  endtask

  task automatic startFrame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic applyStimulus(input bit fs, input bit fe);
    for (int k = 0; k < NUM_PE; k++) begin
      data_in[k*DATA_W +: DATA_W]        = DATA_W'(laneData[k]);
      data_in_rows[k*COORD_W +: COORD_W] = COORD_W'(laneRow[k]);
      data_in_cols[k*COORD_W +: COORD_W] = COORD_W'(laneCol[k]);
    end
    in_valid = 1'b1;
    frame_start = fs;
    frame_end = fe;
    tick();
    in_valid = 1'b0;
    frame_start = 1'b0;
    frame_end = 1'b0;
  endtask

  // stallMode=1 drives out_ready with the repeating pattern 1,0,0,1.
  task automatic drainFrame(input bit stallMode);
    int target;
    bit done;
    target = framesDone + 1;
    done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      out_ready = stallMode ? ((n % 4) == 0 || (n % 4) == 3) : 1'b1;
      tick();
      if (framesDone >= target) done = 1'b1;
    end
    out_ready = 1'b0;
    if (!done) begin
      $display("[TB] FAIL drain_timeout: got %0d frames drained, expected %0d", framesDone, target);
      $fatal(1, "[TB] drain did not complete");
    end
    tick();
    tick();
  endtask

  initial begin
    clearLanes();
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] frame 1: single lane at (2,1), fifteen dropped");
    clearLits(15);
    setLit(11, 3);
    setLit(0, 0);
    setLit(24, 0);
    startFrame();
    clearLanes();
    laneData[0] = 3; laneRow[0] = 2; laneCol[0] = 1;
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b0);

    $display("[TB] frame 2: two beats of full collisions at (0,0)");
    clearLits(0);
    setLit(0, 3200);
    setLit(1, 0);
    startFrame();
    setAllLanes(100, 0, 0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b0);

    $display("[TB] frame 3: restart mid-frame, boundary coordinates dropped");
    clearLits(3);
    setLit(0, 0);
    setLit(24, 0);
    startFrame();
    setAllLanes(9, 0, 0);
    applyStimulus(1'b1, 1'b1);
    setAllLanes(0, 4, 4);
    laneData[0] = 7; laneRow[0] = 0; laneCol[0] = -1;
    laneData[1] = 7; laneRow[1] = 0; laneCol[1] = 5;
    laneData[2] = 7; laneRow[2] = 5; laneCol[2] = 0;
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b0);

    $display("[TB] frame 4: saturation in both directions");
    clearLits(0);
    setLit(6, 32767);
    setLit(18, -32768);
    setLit(12, 0);
    startFrame();
    setAllLanes(32767, 1, 1);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    setAllLanes(-32768, 3, 3);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b0);

    $display("[TB] frame 5: drain under out_ready backpressure");
    clearLits(0);
    setLit(0, 1);
    setLit(8, 8);
    setLit(18, 16);
    setLit(4, 0);
    startFrame();
    for (int k = 0; k < NUM_PE; k++) begin
      laneData[k] = k + 1;
      laneRow[k] = k / 4;
      laneCol[k] = k % 4;
    end
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b1);

    $display("[TB] frame 6: reset during drain, then a fresh frame");
    startFrame();
    setAllLanes(100, 0, 0);
    applyStimulus(1'b0, 1'b1);
    begin
      bit found;
      found = 1'b0;
      out_ready = 1'b1;
      for (int n = 0; n < 60 && !found; n++) begin
        if (out_valid && out_index == 5'd10) found = 1'b1;
        else tick();
      end
      if (!found) begin
        $display("[TB] FAIL drain_index_timeout: got index %0d, expected 10", out_index);
        $fatal(1, "[TB] drain never reached index 10");
      end
    end
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    tick();
    clearLits(15);
    setLit(0, 5);
    setLit(1, 0);
    setLit(10, 0);
    startFrame();
    clearLanes();
    laneData[0] = 5; laneRow[0] = 0; laneCol[0] = 0;
    applyStimulus(1'b0, 1'b1);
    drainFrame(1'b0);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
